// File: rtl/nibble_acc_pkg.sv
// rtl/nibble_acc_pkg.sv - shared types and constants for the nibble accumulator
package nibble_acc_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] NIBBLE_MAX = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_accumulator_module_if.sv
// rtl/nibble_accumulator_module_if.sv - input beat and result handshake bundle
interface nibble_accumulator_module_if;
  import nibble_acc_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [NIBBLE_W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [NIBBLE_W-1:0] sum;
  logic                cout;

  // Producer of beats and consumer of results.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout
  );

  // The accumulator itself.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout
  );

endinterface

// File: rtl/four_bit_full_adder_module.sv
// rtl/four_bit_full_adder_module.sv - 4-bit ripple-carry adder with carry in/out
module four_bit_full_adder_module (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  // One full-adder cell per bit, carry rippling from bit 0 upward.
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[4];

endmodule

// File: rtl/nibble_accumulator_module.sv
// rtl/nibble_accumulator_module.sv - sums BURST_LEN nibble beats; NIBBLE_ACC_SATURATE_EN selects saturating sum
module nibble_accumulator_module
  import nibble_acc_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  nibble_accumulator_module_if.slave  bus
);

  localparam logic [3:0] BURST_LEN_C = 4'(BURST_LEN);

  state_t              state;
  logic [NIBBLE_W-1:0] acc;
  logic                ovf;
  logic [3:0]          cnt;
  logic [3:0]          cnt_next;
  logic [NIBBLE_W-1:0] add_sum;
  logic                add_carry;
  logic [NIBBLE_W-1:0] acc_next;
  logic                ovf_next;
  logic                beat;
  logic                out_valid_q;
  logic [NIBBLE_W-1:0] sum_q;
  logic                cout_q;

  // Ready depends on state alone so upstream never sees a combinational loop.
  assign bus.in_ready = (state != HOLD);
  assign beat         = bus.in_valid && bus.in_ready;

  four_bit_full_adder_module u_adder (
    .a    (acc),
    .b    (bus.in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_carry)
  );

  assign cnt_next = cnt + 4'd1;
  assign ovf_next = ovf | add_carry;

`ifdef NIBBLE_ACC_SATURATE_EN
  // Once any carry has happened in this burst the sum is pinned at full scale.
  assign acc_next = ovf_next ? NIBBLE_MAX : add_sum;
`else
  assign acc_next = add_sum;
`endif

  // Burst FSM: counts accepted beats, then holds the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      ovf         <= 1'b0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (beat) begin
            acc <= acc_next;
            ovf <= ovf_next;
            cnt <= cnt_next;
            if (cnt_next == BURST_LEN_C) begin
              state       <= HOLD;
              out_valid_q <= 1'b1;
              sum_q       <= acc_next;
              cout_q      <= ovf_next;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            acc         <= '0;
            ovf         <= 1'b0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          acc         <= '0;
          ovf         <= 1'b0;
          cnt         <= '0;
          out_valid_q <= 1'b0;
          sum_q       <= '0;
          cout_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_nibble_accumulator_module.sv
// tb/tb_nibble_accumulator_module.sv - directed checks for the nibble accumulator
module tb_nibble_accumulator_module;

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  nibble_accumulator_module_if bus4 ();
  nibble_accumulator_module_if bus1 ();

  nibble_accumulator_module #(.BURST_LEN(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  nibble_accumulator_module #(.BURST_LEN(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat4(input logic [3:0] d);
    bus4.in_valid = 1'b1;
    bus4.in_data  = d;
    tick();
    bus4.in_valid = 1'b0;
  endtask

  task automatic expect4(input string tag, input logic [3:0] s, input logic c);
    check({tag, "_valid"}, {7'd0, bus4.out_valid}, 8'd1);
    check({tag, "_sum"},   {4'd0, bus4.sum},       {4'd0, s});
    check({tag, "_cout"},  {7'd0, bus4.cout},      {7'd0, c});
  endtask

  task automatic collect4(input string tag);
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    check({tag, "_released"}, {7'd0, bus4.out_valid}, 8'd0);
    check({tag, "_sum_zero"}, {4'd0, bus4.sum},       8'd0);
    check({tag, "_ready"},    {7'd0, bus4.in_ready},  8'd1);
  endtask

  initial begin
    bus4.in_valid  = 1'b0;
    bus4.in_data   = 4'd0;
    bus4.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = 4'd0;
    bus1.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_valid", {7'd0, bus4.out_valid}, 8'd0);
    check("rst_ready", {7'd0, bus4.in_ready},  8'd1);
    check("rst_sum",   {4'd0, bus4.sum},       8'd0);
    check("rst_cout",  {7'd0, bus4.cout},      8'd0);

    // 3+4+5+2 = 14, no carry; result one cycle after the last beat
    beat4(4'd3);
    beat4(4'd4);
    beat4(4'd5);
    check("b1_early_valid", {7'd0, bus4.out_valid}, 8'd0);
    beat4(4'd2);
    expect4("b1", 4'd14, 1'b0);
    collect4("b1");

    // 9+9 carries; wrap gives 3, saturate gives 15
    beat4(4'd9);
    beat4(4'd9);
    beat4(4'd1);
    beat4(4'd0);
`ifdef NIBBLE_ACC_SATURATE_EN
    expect4("b2", 4'd15, 1'b1);
`else
    expect4("b2", 4'd3, 1'b1);
`endif
    collect4("b2");

    // stall in HOLD with in_valid asserted: nothing moves, 7s ignored
    beat4(4'd1);
    beat4(4'd2);
    beat4(4'd3);
    beat4(4'd4);
    expect4("b3", 4'd10, 1'b0);
    bus4.in_valid = 1'b1;
    bus4.in_data  = 4'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", {7'd0, bus4.out_valid}, 8'd1);
      check("hold_sum",   {4'd0, bus4.sum},       8'd10);
      check("hold_cout",  {7'd0, bus4.cout},      8'd0);
      check("hold_ready", {7'd0, bus4.in_ready},  8'd0);
    end
    bus4.in_valid = 1'b0;
    collect4("b3");
    beat4(4'd1);
    beat4(4'd1);
    beat4(4'd1);
    check("b4_early_valid", {7'd0, bus4.out_valid}, 8'd0);
    beat4(4'd1);
    expect4("b4", 4'd4, 1'b0);
    collect4("b4");

    // reset mid-burst, with a beat on the same edge, discards everything
    beat4(4'd5);
    beat4(4'd5);
    rst = 1'b1;
    bus4.in_valid = 1'b1;
    bus4.in_data  = 4'd9;
    tick();
    rst = 1'b0;
    bus4.in_valid = 1'b0;
    check("mid_rst_valid", {7'd0, bus4.out_valid}, 8'd0);
    check("mid_rst_ready", {7'd0, bus4.in_ready},  8'd1);
    beat4(4'd1);
    beat4(4'd2);
    beat4(4'd3);
    check("b5_early_valid", {7'd0, bus4.out_valid}, 8'd0);
    beat4(4'd4);
    expect4("b5", 4'd10, 1'b0);
    collect4("b5");

    // gapped beats of 2; out_ready during gaps must be ignored
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
        check("gap_valid", {7'd0, bus4.out_valid}, 8'd0);
      end
      beat4(4'd2);
      if (i < 3) check("gap_beat_valid", {7'd0, bus4.out_valid}, 8'd0);
    end
    expect4("b6", 4'd8, 1'b0);
    collect4("b6");

    // single-beat bursts
    bus1.out_ready = 1'b1;
    bus1.in_valid  = 1'b1;
    bus1.in_data   = 4'd6;
    tick();
    bus1.in_valid  = 1'b0;
    check("l1a_valid", {7'd0, bus1.out_valid}, 8'd1);
    check("l1a_sum",   {4'd0, bus1.sum},       8'd6);
    check("l1a_cout",  {7'd0, bus1.cout},      8'd0);
    tick();
    check("l1a_released", {7'd0, bus1.out_valid}, 8'd0);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 4'd15;
    tick();
    bus1.in_valid = 1'b0;
    check("l1b_valid", {7'd0, bus1.out_valid}, 8'd1);
    check("l1b_sum",   {4'd0, bus1.sum},       8'd15);
    check("l1b_cout",  {7'd0, bus1.cout},      8'd0);
    tick();
    check("l1b_released", {7'd0, bus1.out_valid}, 8'd0);
    bus1.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/nibble_accumulator_module.md
NIBBLE_ACCUMULATOR_MODULE -- requirements
Module: nibble_accumulator_module

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, giving the number of accepted input beats per result; legal range 1..15.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream offers in_data this cycle.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_data  input  4  unsigned nibble operand.
REQ-008 out_valid  output  1  result available on sum/cout.
REQ-009 out_ready  input  1  downstream takes the result this cycle.
REQ-010 sum  output  4  accumulated burst result.
REQ-011 cout  output  1  sticky flag: some addition in the burst produced carry-out.

Function
REQ-012 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-013 Beat accepted iff in_valid && in_ready at a rising clk edge.
REQ-014 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD, decoded combinationally from state only.
REQ-015 On an accepted beat: acc <= acc + in_data (4-bit, cin=0); ovf <= ovf | carry; cnt <= cnt + 1.
REQ-016 IDLE -> ACCUM on first accepted beat; IDLE -> HOLD directly if BURST_LEN = 1.
REQ-017 ACCUM -> HOLD on the accepted beat that makes cnt equal BURST_LEN.
REQ-018 out_valid SHALL be 1 exactly in HOLD; first asserted the cycle after the final beat (latency 1).
REQ-019 In HOLD, sum = acc and cout = ovf; both held stable while out_valid && !out_ready.
REQ-020 HOLD -> IDLE on out_ready; same edge clears acc, ovf and cnt to 0.
REQ-021 in_valid in HOLD SHALL be ignored: no state change, no beat counted.
REQ-022 out_ready outside HOLD SHALL be ignored.
REQ-023 Cycles without in_valid SHALL not advance cnt; gaps are allowed anywhere in a burst.
REQ-024 Outside HOLD, sum and cout SHALL drive 0.

Reset
REQ-025 rst SHALL force state IDLE, acc = 0, ovf = 0, cnt = 0, out_valid = 0, sum = 0, cout = 0, in_ready = 1 on the next edge.
REQ-026 rst SHALL take priority over any simultaneous beat or out_ready.
REQ-027 rst mid-burst or in HOLD SHALL discard the partial or pending result; nothing is emitted.

Configuration
REQ-028 Macro NIBBLE_ACC_SATURATE_EN SHALL select saturating behaviour.
REQ-029 Without the macro: acc wraps modulo 16 and cout reports sticky carry.
REQ-030 With the macro: any carry sets acc to 4'hF; acc remains 4'hF for the rest of the burst; cout is still sticky.

Structure
REQ-031 Shared package nibble_acc_pkg SHALL hold the state encoding (IDLE, ACCUM, HOLD), NIBBLE_W = 4 and NIBBLE_MAX = 4'hF.
REQ-032 The addition SHALL use one instance of four_bit_full_adder_module, with a = acc, b = in_data and cin tied to 0.
REQ-033 cnt SHALL be 4 bits wide; no other arithmetic beyond the increment.

Verification
REQ-034 BURST_LEN=4; after reset send beats 3, 4, 5, 2 back-to-back -> out_valid = 1 the cycle after the 4th beat; sum = 14; cout = 0.
REQ-035 Send beats 9, 9, 1, 0 -> default build: sum = 3, cout = 1; with NIBBLE_ACC_SATURATE_EN: sum = 15, cout = 1.
REQ-036 Hold out_ready = 0 for 5 cycles in HOLD while in_valid = 1 with data 7 -> sum and cout stable, in_ready = 0. Then raise out_ready -> IDLE; the next burst of 1, 1, 1, 1 gives sum = 4 (no 7s counted).
REQ-037 Assert rst after 2 accepted beats (5, 5), then send 1, 2, 3, 4 -> single result sum = 10, cout = 0.
REQ-038 Toggle in_valid every other cycle with data 2 -> result after exactly 4 accepted beats; sum = 8.
REQ-039 BURST_LEN=1; send beats 6 then 15 with out_ready = 1 -> two results: sum = 6 then 15, cout = 0 each time.
